// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, runs the instruction-memory busywait handshake, absorbs
// hazard stalls and EX-stage redirects, and hands decode a registered
// instruction with its PC and PC+4. Bubbles are the canonical NOP.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] target_reg, target_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] id_pc_reg, id_pc_next;
    logic [31:0] id_pc4_reg, id_pc4_next;
    logic        valid_reg, valid_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_reg + 32'd4;

    // Next-state, PC and IF/ID selection; priority is redirect > stall > fetch.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        target_next = target_reg;
        instr_next  = instr_reg;
        id_pc_next  = id_pc_reg;
        id_pc4_next = id_pc4_reg;
        valid_next  = valid_reg;
        count_next  = count_reg;
        case (state_reg)
            ST_IDLE: begin
                // First cycle out of reset: no request yet, IF/ID stays a bubble.
                instr_next = NOP_INSTR;
                valid_next = 1'b0;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (branch_taken) begin
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                    if (!imem_busywait) begin
                        // Wrong-path word is dropped; redirect right away.
                        pc_next = branch_target;
                    end else begin
                        // Address must stay put until memory finishes, so park the target.
                        target_next = branch_target;
                        state_next  = ST_DRAIN;
                    end
                end else if (stall) begin
                    // Hold everything; any returned word will be fetched again.
                    pc_next = pc_reg;
                end else if (imem_busywait) begin
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end else begin
                    instr_next  = imem_readdata;
                    id_pc_next  = pc_reg;
                    id_pc4_next = pc_plus4;
                    valid_next  = 1'b1;
                    pc_next     = pc_plus4;
                    count_next  = count_reg + 32'd1;
                end
            end
            ST_DRAIN: begin
                instr_next = NOP_INSTR;
                valid_next = 1'b0;
                if (branch_taken) begin
                    target_next = branch_target;
                end
                if (!imem_busywait) begin
                    // The newest redirect wins, even if it arrives this very cycle.
                    pc_next    = branch_taken ? branch_target : target_reg;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and pipeline-register update with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            target_reg <= 32'd0;
            instr_reg  <= NOP_INSTR;
            id_pc_reg  <= 32'd0;
            id_pc4_reg <= 32'd0;
            valid_reg  <= 1'b0;
            count_reg  <= 32'd0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            target_reg <= target_next;
            instr_reg  <= instr_next;
            id_pc_reg  <= id_pc_next;
            id_pc4_reg <= id_pc4_next;
            valid_reg  <= valid_next;
            count_reg  <= count_next;
        end
    end

    assign imem_addr         = pc_reg;
    assign imem_read         = (state_reg != ST_IDLE);
    assign if_id_instruction = instr_reg;
    assign if_id_pc          = id_pc_reg;
    assign if_id_pc4         = id_pc4_reg;
    assign if_id_valid       = valid_reg;
    assign fetch_count       = count_reg;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: stimulus pushes the expected
// post-edge outputs from a behavioural fetch model, a monitor pops and compares.
module tb_if_id_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h00000000;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_readdata;
    logic        imem_busywait = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    if_id_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .CLK(CLK), .RESET(RESET),
        .imem_addr(imem_addr), .imem_read(imem_read),
        .imem_readdata(imem_readdata), .imem_busywait(imem_busywait),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    always #5 CLK = ~CLK;

    // Instruction memory contents: an addi word that encodes its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h20) return 32'h00A00093;
        return {a[13:2] ^ 12'h5A3, 20'h00093};
    endfunction

    // Word is garbage while busy so a wrongly captured busy word is visible.
    assign imem_readdata = imem_busywait ? 32'hDEADBEEF : mem_word(imem_addr);

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] count;
        logic [31:0] addr;
        logic        rd;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Behavioural model: what decode should see, in terms of program flow.
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt, m_pending;
    logic        m_valid, m_just_reset, m_redirect_pending;

    task automatic model_step(input logic rst, input logic br, input logic [31:0] tgt,
                              input logic st, input logic bz);
        if (rst) begin
            m_pc = RESET_PC; m_just_reset = 1'b1; m_redirect_pending = 1'b0;
            m_instr = NOP_INSTR; m_valid = 1'b0; m_ipc = 0; m_ipc4 = 0; m_cnt = 0;
        end else if (m_just_reset) begin
            m_just_reset = 1'b0;
            m_instr = NOP_INSTR; m_valid = 1'b0;
        end else if (m_redirect_pending) begin
            m_instr = NOP_INSTR; m_valid = 1'b0;
            if (br) m_pending = tgt;
            if (!bz) begin
                m_pc = m_pending;
                m_redirect_pending = 1'b0;
            end
        end else if (br) begin
            m_instr = NOP_INSTR; m_valid = 1'b0;
            if (!bz) m_pc = tgt;
            else begin
                m_pending = tgt;
                m_redirect_pending = 1'b1;
            end
        end else if (st) begin
            // nothing moves
        end else if (bz) begin
            m_instr = NOP_INSTR; m_valid = 1'b0;
        end else begin
            m_instr = mem_word(m_pc); m_valid = 1'b1;
            m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        end
    endtask

    // One clock of stimulus: drive at negedge, predict, queue the expectation.
    task automatic cyc(input logic rst, input logic br, input logic [31:0] tgt,
                       input logic st, input logic bz);
        exp_t e;
        @(negedge CLK);
        RESET = rst; branch_taken = br; branch_target = tgt;
        stall = st; imem_busywait = bz;
        model_step(rst, br, tgt, st, bz);
        e.instr = m_instr; e.valid = m_valid; e.pc = m_ipc; e.pc4 = m_ipc4;
        e.count = m_cnt; e.addr = m_pc; e.rd = !m_just_reset;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%08h required=%08h", name, $time, act, req);
        end
    endtask

    // Monitor: after every edge compare the DUT against the oldest expectation.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("instr", if_id_instruction, e.instr);
            chk("valid", {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("count", fetch_count, e.count);
            chk("imem_addr", imem_addr, e.addr);
            chk("imem_read", {31'd0, imem_read}, {31'd0, e.rd});
            if (e.valid) begin
                chk("if_id_pc", if_id_pc, e.pc);
                chk("if_id_pc4", if_id_pc4, e.pc4);
            end
            $display("cyc t=%0t pc=%08h instr=%08h v=%0b id_pc=%08h cnt=%0d",
                     $time, imem_addr, if_id_instruction, if_id_valid, if_id_pc, fetch_count);
        end
    end

    initial begin
        int guard;
        m_pc = RESET_PC; m_instr = NOP_INSTR; m_ipc = 0; m_ipc4 = 0; m_cnt = 0;
        m_pending = 0; m_valid = 0; m_just_reset = 1; m_redirect_pending = 0;

        // Reset, then zero-wait fetch of 0, 4, 8, 0xC.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0);
        // Memory busy for 3 cycles at 0x10.
        repeat (3) cyc(0, 0, 0, 0, 1);
        // Advance to PC=0x20 inclusive, then stall twice with 0x20 in IF/ID.
        guard = 0;
        while (m_ipc != 32'h20 && guard < 50) begin cyc(0, 0, 0, 0, 0); guard++; end
        repeat (2) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        // Advance to PC=0x40, branch while busy, drain, then fetch target.
        guard = 0;
        while (m_pc != 32'h40 && guard < 50) begin cyc(0, 0, 0, 0, 0); guard++; end
        cyc(0, 1, 32'h100, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        // Branch together with stall, zero-wait.
        cyc(0, 1, 32'h200, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        // Reset in the middle of a drain with a pending target.
        cyc(0, 1, 32'h300, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        // PC wrap across 0xFFFFFFFC.
        cyc(0, 1, 32'hFFFFFFF8, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        // Redirect arriving during drain overrides the saved target.
        cyc(0, 1, 32'h500, 0, 1);
        cyc(0, 1, 32'h600, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic r, b, s, w;
            logic [31:0] t;
            r = ($urandom_range(0, 79) == 0);
            b = ($urandom_range(0, 5) == 0);
            s = ($urandom_range(0, 4) == 0);
            w = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: t = $urandom;
                1: t = 32'hFFFFFFF0 | ($urandom_range(0, 3) << 2);
                default: t = {18'd0, $urandom_range(0, 4095) & 12'hFFC, 2'b00};
            endcase
            cyc(r, b, t, s, w);
        end

        @(negedge CLK);
        RESET = 0; branch_taken = 0; stall = 1; imem_busywait = 1;
        @(posedge CLK); #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
